// File: rtl/sa_cache_array_lfu_pkg.sv
// Shared types for the set-associative cache array: request opcodes,
// storage typedefs at default widths, and the LFU aging helper.
package sa_cache_array_lfu_pkg;

  localparam int unsigned ARR_TAG_W  = 18;
  localparam int unsigned ARR_LINE_W = 128;
  localparam int unsigned ARR_CNT_W  = 4;

  typedef enum logic [1:0] {
    ARR_LOOKUP = 2'd0,
    ARR_FILL   = 2'd1,
    ARR_INVAL  = 2'd2
  } cache_arr_op_t;

  typedef logic [ARR_TAG_W-1:0]  arr_tag_t;
  typedef logic [ARR_LINE_W-1:0] arr_line_t;
  typedef logic [ARR_CNT_W-1:0]  lfu_cnt_t;

  // Aging halves a use counter; wide argument so any counter width fits.
  function automatic logic [31:0] lfu_age(input logic [31:0] cnt);
    return cnt >> 1;
  endfunction

endpackage

// File: rtl/sa_cache_array_lfu_victim_sel.sv
// Combinational LFU victim pick: lowest invalid way, else lowest-index
// way holding the minimum use counter.
module lfu_victim_sel #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic [WAYS-1:0]       valid,
  input  logic [WAYS*CNT_W-1:0] cnt,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int unsigned WAY_W = $clog2(WAYS);

  logic             found_inv;
  logic [CNT_W-1:0] best;

  always_comb begin
    victim    = '0;
    found_inv = 1'b0;
    best      = cnt[CNT_W-1:0];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valid[w] && !found_inv) begin
        victim    = WAY_W'(w);
        found_inv = 1'b1;
      end
    end
    if (!found_inv) begin
      // Strict less-than keeps the lowest index on ties.
      for (int unsigned w = 1; w < WAYS; w++) begin
        if (cnt[w*CNT_W +: CNT_W] < best) begin
          best   = cnt[w*CNT_W +: CNT_W];
          victim = WAY_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/sa_cache_array_lfu.sv
// N-way set-associative tag/data array with per-set LFU state; one-cycle
// LOOKUP pipeline, FILL/INVAL written at the accept edge.
module sa_cache_array_lfu
  import sa_cache_array_lfu_pkg::*;
#(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 1024,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned TAG_W  = 18,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [$clog2(SETS)-1:0] req_index,
  input  logic [TAG_W-1:0]        req_tag,
  input  logic [$clog2(WAYS)-1:0] req_way,
  input  logic [LINE_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_hit,
  output logic [$clog2(WAYS)-1:0] rsp_way,
  output logic [LINE_W-1:0]       rsp_rdata,
  output logic [$clog2(WAYS)-1:0] rsp_victim
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (WAYS < 2 || WAYS > 8 || (WAYS & (WAYS - 1)) != 0 || (SETS & (SETS - 1)) != 0) begin : g_bad_param
    $error("sa_cache_array_lfu: WAYS must be a power of 2 in 2..8 and SETS a power of 2");
  end

  logic [TAG_W-1:0]  tag_ram  [WAYS][SETS];
  logic [LINE_W-1:0] data_ram [WAYS][SETS];
  logic [SETS-1:0]   valid_q  [WAYS];
  logic [CNT_W-1:0]  cnt_q    [WAYS][SETS];

  logic              ready_q;
  logic              s2_valid;
  logic [IDX_W-1:0]  s2_index;
  logic [TAG_W-1:0]  s2_tag;
  logic [WAYS-1:0]   s2_vbits;
  logic [CNT_W-1:0]  s2_cnt  [WAYS];
  logic [TAG_W-1:0]  s2_tags [WAYS];
  logic [LINE_W-1:0] s2_data [WAYS];

  logic                  accept, acc_lookup, acc_fill, acc_inval, fwd;
  logic [WAYS-1:0]       match;
  logic                  hit, aging;
  logic [WAY_W-1:0]      hit_way, victim;
  logic [CNT_W-1:0]      upd_cnt [WAYS];
  logic [WAYS*CNT_W-1:0] s2_cnt_flat;

  assign accept     = req_valid && ready_q;
  assign acc_lookup = accept && (req_op == ARR_LOOKUP);
  assign acc_fill   = accept && (req_op == ARR_FILL);
  assign acc_inval  = accept && (req_op == ARR_INVAL);
  assign fwd        = s2_valid && hit && (s2_index == req_index);

  always_comb begin
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      match[w] = s2_vbits[w] && (s2_tags[w] == s2_tag);
      s2_cnt_flat[w*CNT_W +: CNT_W] = s2_cnt[w];
    end
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (match[w-1]) hit_way = WAY_W'(w - 1);
    end
    hit   = |match;
    aging = (s2_cnt[hit_way] == CNT_MAX);
    // Saturated hit halves the whole set before incrementing, so no wrap.
    for (int unsigned w = 0; w < WAYS; w++) begin
      upd_cnt[w] = aging ? CNT_W'(lfu_age(32'(s2_cnt[w]))) : s2_cnt[w];
    end
    upd_cnt[hit_way] = upd_cnt[hit_way] + CNT_W'(1);
  end

  lfu_victim_sel #(.WAYS(WAYS), .CNT_W(CNT_W)) u_victim (
    .valid  (s2_vbits),
    .cnt    (s2_cnt_flat),
    .victim (victim)
  );

  assign req_ready  = ready_q;
  assign rsp_valid  = s2_valid;
  assign rsp_hit    = s2_valid && hit;
  assign rsp_way    = rsp_hit ? hit_way : '0;
  assign rsp_rdata  = rsp_hit ? s2_data[hit_way] : '0;
  assign rsp_victim = s2_valid ? victim : '0;

  always_ff @(posedge clk) begin
    if (acc_fill) begin
      tag_ram[req_way][req_index]  <= req_tag;
      data_ram[req_way][req_index] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      s2_valid <= 1'b0;
      s2_index <= '0;
      s2_tag   <= '0;
      s2_vbits <= '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        s2_cnt[w]  <= '0;
        s2_tags[w] <= '0;
        s2_data[w] <= '0;
        valid_q[w] <= '0;
        for (int unsigned s = 0; s < SETS; s++) cnt_q[w][s] <= '0;
      end
    end else begin
      ready_q  <= 1'b1;
      s2_valid <= acc_lookup;
      if (acc_lookup) begin
        s2_index <= req_index;
        s2_tag   <= req_tag;
        for (int unsigned w = 0; w < WAYS; w++) begin
          s2_vbits[w] <= valid_q[w][req_index];
          s2_cnt[w]   <= fwd ? upd_cnt[w] : cnt_q[w][req_index];
          s2_tags[w]  <= tag_ram[w][req_index];
          s2_data[w]  <= data_ram[w][req_index];
        end
      end
      if (s2_valid && hit) begin
        for (int unsigned w = 0; w < WAYS; w++) cnt_q[w][s2_index] <= upd_cnt[w];
      end
      // Later assignments win: a same-cycle FILL/INVAL overrides the LFU update of its way.
      if (acc_fill) begin
        valid_q[req_way][req_index] <= 1'b1;
        cnt_q[req_way][req_index]   <= CNT_W'(1);
      end
      if (acc_inval) begin
        valid_q[req_way][req_index] <= 1'b0;
        cnt_q[req_way][req_index]   <= '0;
      end
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (!rst_n) s2_valid |-> $onehot0(match))
    else $error("sa_cache_array_lfu: multiple ways hit in set %0d", s2_index);

endmodule
